// File: rtl/rs_frame_checker.sv
// End-of-chain checker for the RS(15,11) test path: buffers the clean codeword,
// scores the decoder's corrected stream against it and keeps pass/fail frame tallies.
module rs_frame_checker #(
    parameter int N_SYM = 15,
    parameter int SYM_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ref_start,
    input  logic [SYM_W-1:0] ref_data,
    input  logic             dec_start,
    input  logic [SYM_W-1:0] dec_data,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_count,
    output logic [5:0]       bit_err_count,
    output logic [3:0]       first_err_pos,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad,
    output logic             proto_err
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        HOLD,
        COMPARE,
        REPORT
    } state_t;

    localparam logic [3:0]       LAST_K  = 4'(N_SYM - 1);
    localparam logic [3:0]       NO_POS  = 4'hF;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [3:0]       k;
    logic [SYM_W-1:0] frame_buf [N_SYM];

    logic [3:0]       sym_acc;
    logic [5:0]       bit_acc;
    logic [3:0]       pos_acc;

    logic [SYM_W-1:0] diff;
    logic [3:0]       sym_next;
    logic [5:0]       bit_next;
    logic [3:0]       pos_next;

    function automatic logic [5:0] popcount(input logic [SYM_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < SYM_W; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

    // Accumulators including the symbol being compared this cycle, so the
    // final COMPARE cycle can publish the complete frame result directly.
    always_comb begin
        diff     = dec_data ^ frame_buf[k];
        sym_next = (diff != '0) ? sym_acc + 4'd1 : sym_acc;
        bit_next = bit_acc + popcount(diff);
        pos_next = ((diff != '0) && (sym_acc == 4'd0)) ? k : pos_acc;
    end

    // The buffer needs no reset; its contents are only read after a full capture.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            frame_buf[k] <= ref_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            k             <= '0;
            sym_acc       <= '0;
            bit_acc       <= '0;
            pos_acc       <= NO_POS;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            bit_err_count <= '0;
            first_err_pos <= NO_POS;
            frames_ok     <= '0;
            frames_bad    <= '0;
            proto_err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dec_start) begin
                        proto_err <= 1'b1;
                    end
                    if (ref_start) begin
                        state <= CAPTURE;
                        k     <= '0;
                    end
                end

                CAPTURE: begin
                    if (ref_start || dec_start) begin
                        proto_err <= 1'b1;
                    end
                    if (k == LAST_K) begin
                        state <= HOLD;
                        k     <= '0;
                    end else begin
                        k <= k + 4'd1;
                    end
                end

                HOLD: begin
                    if (ref_start) begin
                        proto_err <= 1'b1;
                    end
                    if (dec_start) begin
                        state   <= COMPARE;
                        k       <= '0;
                        sym_acc <= '0;
                        bit_acc <= '0;
                        pos_acc <= NO_POS;
                    end
                end

                COMPARE: begin
                    if (ref_start || dec_start) begin
                        proto_err <= 1'b1;
                    end
                    sym_acc <= sym_next;
                    bit_acc <= bit_next;
                    pos_acc <= pos_next;
                    // Results are registered here so they are visible together with done.
                    if (k == LAST_K) begin
                        state         <= REPORT;
                        k             <= '0;
                        done          <= 1'b1;
                        pass          <= (sym_next == 4'd0);
                        err_count     <= sym_next;
                        bit_err_count <= bit_next;
                        first_err_pos <= pos_next;
                        if (sym_next == 4'd0) begin
                            if (frames_ok != CNT_MAX) begin
                                frames_ok <= frames_ok + 1'b1;
                            end
                        end else begin
                            if (frames_bad != CNT_MAX) begin
                                frames_bad <= frames_bad + 1'b1;
                            end
                        end
                    end else begin
                        k <= k + 4'd1;
                    end
                end

                REPORT: begin
                    if (dec_start) begin
                        proto_err <= 1'b1;
                    end
                    if (ref_start) begin
                        state <= CAPTURE;
                        k     <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    k     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_frame_checker.sv
// Testbench for rs_frame_checker: directed frame table, protocol/reset corner
// sequences and randomized frames scored by a frame-level reference model.
module tb_rs_frame_checker;

    logic       clk;
    logic       reset;
    logic       ref_start;
    logic [3:0] ref_data;
    logic       dec_start;
    logic [3:0] dec_data;

    logic       done, pass, proto_err;
    logic [3:0] err_count, first_err_pos;
    logic [5:0] bit_err_count;
    logic [7:0] frames_ok, frames_bad;

    logic       sat_done, sat_pass, sat_proto_err;
    logic [3:0] sat_err_count, sat_first_err_pos;
    logic [5:0] sat_bit_err_count;
    logic [1:0] sat_frames_ok, sat_frames_bad;

    int checks;
    int failures;

    logic       exp_pass;
    logic [3:0] exp_err;
    logic [5:0] exp_bits;
    logic [3:0] exp_pos;
    logic       exp_proto;
    int         n_ok;
    int         n_bad;

    rs_frame_checker #(.N_SYM(15), .SYM_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ref_start(ref_start), .ref_data(ref_data),
        .dec_start(dec_start), .dec_data(dec_data),
        .done(done), .pass(pass), .err_count(err_count),
        .bit_err_count(bit_err_count), .first_err_pos(first_err_pos),
        .frames_ok(frames_ok), .frames_bad(frames_bad), .proto_err(proto_err)
    );

    rs_frame_checker #(.N_SYM(15), .SYM_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .ref_start(ref_start), .ref_data(ref_data),
        .dec_start(dec_start), .dec_data(dec_data),
        .done(sat_done), .pass(sat_pass), .err_count(sat_err_count),
        .bit_err_count(sat_bit_err_count), .first_err_pos(sat_first_err_pos),
        .frames_ok(sat_frames_ok), .frames_bad(sat_frames_bad), .proto_err(sat_proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [59:0] ref_w;
        logic [59:0] mask;
        bit          chain;
        logic        exp_p;
        logic [3:0]  exp_e;
        logic [5:0]  exp_b;
        logic [3:0]  exp_ps;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int sat_to(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic checkOutput(input string tag, input logic exp_done);
        chk({tag, " done"},           32'(done),           32'(exp_done));
        chk({tag, " pass"},           32'(pass),           32'(exp_pass));
        chk({tag, " err_count"},      32'(err_count),      32'(exp_err));
        chk({tag, " bit_err_count"},  32'(bit_err_count),  32'(exp_bits));
        chk({tag, " first_err_pos"},  32'(first_err_pos),  32'(exp_pos));
        chk({tag, " proto_err"},      32'(proto_err),      32'(exp_proto));
        chk({tag, " frames_ok"},      32'(frames_ok),      32'(sat_to(n_ok, 255)));
        chk({tag, " frames_bad"},     32'(frames_bad),     32'(sat_to(n_bad, 255)));
        chk({tag, " sat done"},       32'(sat_done),       32'(exp_done));
        chk({tag, " sat pass"},       32'(sat_pass),       32'(exp_pass));
        chk({tag, " sat err_count"},  32'(sat_err_count),  32'(exp_err));
        chk({tag, " sat bit_err"},    32'(sat_bit_err_count), 32'(exp_bits));
        chk({tag, " sat first_pos"},  32'(sat_first_err_pos), 32'(exp_pos));
        chk({tag, " sat proto_err"},  32'(sat_proto_err),  32'(exp_proto));
        chk({tag, " sat frames_ok"},  32'(sat_frames_ok),  32'(sat_to(n_ok, 3)));
        chk({tag, " sat frames_bad"}, 32'(sat_frames_bad), 32'(sat_to(n_bad, 3)));
    endtask

    task automatic step(input string tag, input logic exp_done);
        @(negedge clk);
        checkOutput(tag, exp_done);
    endtask

    task automatic clear_model();
        exp_pass  = 1'b0;
        exp_err   = 4'd0;
        exp_bits  = 6'd0;
        exp_pos   = 4'hF;
        exp_proto = 1'b0;
        n_ok      = 0;
        n_bad     = 0;
    endtask

    // Frame-level reference: list of mismatching symbol indices plus total flipped bits.
    task automatic model_frame(input logic [59:0] rw, input logic [59:0] dw,
                               output logic p, output logic [3:0] e,
                               output logic [5:0] b, output logic [3:0] ps);
        int          bad_idx [$];
        logic [59:0] diff;
        diff = rw ^ dw;
        for (int i = 0; i < 15; i++) begin
            if (diff[4*i +: 4] != 4'd0) bad_idx.push_back(i);
        end
        e  = 4'(bad_idx.size());
        p  = (bad_idx.size() == 0);
        b  = 6'($countones(diff));
        ps = (bad_idx.size() == 0) ? 4'hF : 4'(bad_idx[0]);
    endtask

    task automatic applyStimulus(input logic [59:0] rw, input logic [59:0] dw,
                                 input int hold, input bit started, input bit chain,
                                 input bit poke, input bit dec_too,
                                 input logic exp_p, input logic [3:0] exp_e,
                                 input logic [5:0] exp_b, input logic [3:0] exp_ps,
                                 input string tag);
        if (!started) begin
            step(tag, 1'b0);
            ref_start = 1'b1;
            dec_start = dec_too;
            if (dec_too) exp_proto = 1'b1;
        end
        for (int i = 0; i < 15; i++) begin
            step(tag, 1'b0);
            ref_start = 1'b0;
            dec_start = 1'b0;
            ref_data  = rw[4*i +: 4];
            dec_data  = 4'($urandom);
        end
        for (int h = 0; h < hold; h++) begin
            step(tag, 1'b0);
            ref_data  = 4'($urandom);
            ref_start = poke && (h == 0);
            if (poke && (h == 0)) exp_proto = 1'b1;
        end
        step(tag, 1'b0);
        ref_start = 1'b0;
        dec_start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(tag, 1'b0);
            dec_start = 1'b0;
            dec_data  = dw[4*i +: 4];
            ref_data  = 4'($urandom);
        end
        exp_pass = exp_p;
        exp_err  = exp_e;
        exp_bits = exp_b;
        exp_pos  = exp_ps;
        if (exp_p) n_ok++;
        else       n_bad++;
        step({tag, " report"}, 1'b1);
        dec_data  = 4'($urandom);
        ref_start = chain;
    endtask

    initial begin
        logic [59:0] ref_seq;
        logic [59:0] rw, dw, mask;
        logic        mp;
        logic [3:0]  me, mps;
        logic [5:0]  mb;
        bit          prev_chain;
        bit          ch;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        ref_start = 1'b0;
        dec_start = 1'b0;
        ref_data  = 4'd0;
        dec_data  = 4'd0;
        clear_model();

        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) ref_seq[4*i +: 4] = 4'(i);

        tbl[0] = '{ref_w: ref_seq, mask: 60'h0,      chain: 1'b0, exp_p: 1'b1, exp_e: 4'd0,  exp_b: 6'd0,  exp_ps: 4'hF};
        tbl[1] = '{ref_w: ref_seq, mask: 60'h80080,  chain: 1'b0, exp_p: 1'b0, exp_e: 4'd2,  exp_b: 6'd2,  exp_ps: 4'd1};
        tbl[2] = '{ref_w: ref_seq, mask: {60{1'b1}}, chain: 1'b1, exp_p: 1'b0, exp_e: 4'd15, exp_b: 6'd60, exp_ps: 4'd0};
        tbl[3] = '{ref_w: ref_seq, mask: 60'h0,      chain: 1'b0, exp_p: 1'b1, exp_e: 4'd0,  exp_b: 6'd0,  exp_ps: 4'hF};

        for (int i = 0; i < 4; i++) begin
            applyStimulus(tbl[i].ref_w, tbl[i].ref_w ^ tbl[i].mask, 1 + (i % 2),
                          (i > 0) && tbl[i-1].chain, tbl[i].chain, 1'b0, 1'b0,
                          tbl[i].exp_p, tbl[i].exp_e, tbl[i].exp_b, tbl[i].exp_ps,
                          $sformatf("table%0d", i));
        end

        // ref_start while holding a frame must not disturb the buffered frame.
        rw = {$urandom, $urandom};
        applyStimulus(rw, rw ^ (60'h3 << 36), 3, 1'b0, 1'b0, 1'b1, 1'b0,
                      1'b0, 4'd1, 6'd2, 4'd9, "hold_poke");

        // Reset in the 7th COMPARE cycle aborts the frame asynchronously.
        step("midreset", 1'b0);
        ref_start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step("midreset", 1'b0);
            ref_start = 1'b0;
            ref_data  = 4'(i);
        end
        step("midreset", 1'b0);
        dec_start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("midreset", 1'b0);
            dec_start = 1'b0;
            dec_data  = 4'(i) ^ 4'h1;
        end
        step("midreset", 1'b0);
        #2;
        reset = 1'b1;
        clear_model();
        #1;
        checkOutput("async reset", 1'b0);
        step("in reset", 1'b0);
        reset = 1'b0;

        step("idle dec", 1'b0);
        dec_start = 1'b1;
        exp_proto = 1'b1;
        step("idle dec", 1'b0);
        dec_start = 1'b0;
        repeat (3) step("idle dec", 1'b0);

        rw = {$urandom, $urandom};
        applyStimulus(rw, rw, 0, 1'b0, 1'b0, 1'b0, 1'b1,
                      1'b1, 4'd0, 6'd0, 4'hF, "simul_start");

        step("reset2", 1'b0);
        reset = 1'b1;
        clear_model();
        step("reset2", 1'b0);
        reset = 1'b0;

        prev_chain = 1'b0;
        for (int f = 0; f < 30; f++) begin
            rw   = {$urandom, $urandom};
            mask = '0;
            if (f >= 5) begin
                for (int s = 0; s < 15; s++) begin
                    if ($urandom_range(0, 3) == 0) mask[4*s +: 4] = 4'($urandom_range(1, 15));
                end
            end
            dw = rw ^ mask;
            model_frame(rw, dw, mp, me, mb, mps);
            ch = (f < 29) && ($urandom_range(0, 2) == 0);
            applyStimulus(rw, dw, $urandom_range(0, 3), prev_chain, ch, 1'b0, 1'b0,
                          mp, me, mb, mps, $sformatf("rand%0d", f));
            prev_chain = ch;
        end
        repeat (3) step("tail", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
